// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment counter.
package seg_pkg;

  localparam int DEFAULT_CLK_FREQ = 125_000_000;
  localparam int AN_W             = 4;

  // Index n holds the active-high pattern for hex digit n; bit7 (dp) is always clear.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h27, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter; carry_o tells the next digit to step.
module bcd_digit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [3:0] value_o,
  output logic       carry_o
);

  logic [3:0] val_q, val_d;

  assign carry_o = inc_i && (val_q == 4'd9);
  assign value_o = val_q;

  always_comb begin
    val_d = val_q;
    if (clr_i)      val_d = 4'd0;
    else if (inc_i) val_d = (val_q == 4'd9) ? 4'd0 : val_q + 4'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) val_q <= 4'd0;
    else       val_q <= val_d;
  end

endmodule

// File: rtl/seg_scan4.sv
// Four-digit BCD event counter with a guarded, time-multiplexed seven-segment scan.
module seg_scan4
  import seg_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int SCAN_HZ  = 1_000,
  parameter int GUARD    = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            TICK,
  input  logic            CLR,
  input  logic            HOLD,
  input  logic            LZB,
  output logic [7:0]      Segment,
  output logic [AN_W-1:0] AN,
  output logic            CARRY
);

  localparam int P  = CLK_FREQ / SCAN_HZ;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  if (!(GUARD >= 1 && GUARD < P)) begin : g_bad_guard
    $error("seg_scan4: GUARD must satisfy 1 <= GUARD < CLK_FREQ/SCAN_HZ");
  end

  logic [3:0][3:0] dig;
  logic [4:0]      inc;

  // HOLD and CLR swallow the tick at the head of the ripple chain.
  assign inc[0] = TICK && !CLR && !HOLD;

  for (genvar k = 0; k < 4; k++) begin : g_dig
    bcd_digit u_dig (
      .clk_i   (CLK),
      .rst_i   (RST),
      .clr_i   (CLR),
      .inc_i   (inc[k]),
      .value_o (dig[k]),
      .carry_o (inc[k+1])
    );
  end

  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  scan_state_e     state_q, state_d;
  logic [AN_W-1:0] an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic            carry_q;
  logic            wrap;
  logic [3:0]      hi_zero;

  assign wrap = (presc_q == PW'(P - 1));

  always_comb begin
    presc_d = wrap ? '0 : presc_q + PW'(1);
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    state_d = state_q;
    case (state_q)
      ST_GUARD: if (presc_q == PW'(GUARD - 1)) state_d = ST_SHOW;
      ST_SHOW:  if (wrap)                      state_d = ST_GUARD;
      default:                                 state_d = ST_GUARD;
    endcase
  end

  // hi_zero[k]: digit k and everything above it are zero (candidate for blanking).
  always_comb begin
    hi_zero[3] = (dig[3] == 4'd0);
    hi_zero[2] = hi_zero[3] && (dig[2] == 4'd0);
    hi_zero[1] = hi_zero[2] && (dig[1] == 4'd0);
    hi_zero[0] = hi_zero[1] && (dig[0] == 4'd0);
  end

  // Outputs are computed from next-cycle scan position so the registers line up with state_q.
  always_comb begin
    an_d  = '0;
    seg_d = SEG_TABLE[dig[idx_d]];
    if (state_d == ST_SHOW) an_d = AN_W'(1) << idx_d;
    if (LZB && (idx_d != 2'd0) && hi_zero[idx_d]) seg_d = 8'h00;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      state_q <= ST_GUARD;
      an_q    <= '0;
      seg_q   <= 8'h00;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      carry_q <= inc[4];
    end
  end

  assign AN      = an_q;
  assign Segment = seg_q;
  assign CARRY   = carry_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Directed bench for seg_scan4 with P=10, GUARD=2.
module tb_seg_scan4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TICK = 1'b0, CLR = 1'b0, HOLD = 1'b0, LZB = 1'b0;
  logic [7:0] Segment;
  logic [3:0] AN;
  logic       CARRY;

  int n_chk = 0, n_err = 0;
  int an_bad = 0, carry_cnt = 0;

  seg_scan4 #(.CLK_FREQ(1000), .SCAN_HZ(100), .GUARD(2)) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .CLR(CLR), .HOLD(HOLD), .LZB(LZB),
    .Segment(Segment), .AN(AN), .CARRY(CARRY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if ($countones(AN) > 1) an_bad++;
    if (CARRY) carry_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic tick_n(input int n);
    TICK = 1'b1;
    repeat (n) @(posedge CLK);
    #1 TICK = 1'b0;
  endtask

  task automatic read_seg(input logic [3:0] an, input logic [7:0] exp, input string tag);
    int i;
    for (i = 0; i < 60; i++) begin
      if (AN === an) break;
      step();
    end
    if (i == 60) chk({tag, "_timeout"}, 32'(AN), 32'(an));
    else         chk(tag, 32'(Segment), 32'(exp));
  endtask

  task automatic read_all(input logic [7:0] s3, s2, s1, s0, input string tag);
    read_seg(4'b1000, s3, {tag, "_d3"});
    read_seg(4'b0100, s2, {tag, "_d2"});
    read_seg(4'b0010, s1, {tag, "_d1"});
    read_seg(4'b0001, s0, {tag, "_d0"});
  endtask

  // Expects RST high at the #1 phase; releases it and checks the scan cycle by cycle.
  task automatic scan_from_reset(input int ncyc);
    logic [3:0] exp_an;
    RST = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) step();
      if (c < 2 || (c >= 10 && c < 12)) exp_an = 4'b0000;
      else if (c < 10)                  exp_an = 4'b0001;
      else                              exp_an = 4'b0010;
      chk($sformatf("scan_an_c%0d", c), 32'(AN), 32'(exp_an));
      if (exp_an != 4'b0000) chk($sformatf("scan_seg_c%0d", c), 32'(Segment), 32'h3F);
    end
  endtask

  int cc;

  initial begin
    repeat (2) step();
    chk("rst_an", 32'(AN), 32'h0);
    chk("rst_seg", 32'(Segment), 32'h0);
    chk("rst_carry", 32'(CARRY), 32'h0);
    scan_from_reset(20);

    LZB = 1'b1;
    read_seg(4'b0001, 8'h3F, "lzb_zero_d0");
    read_seg(4'b0010, 8'h00, "lzb_zero_d1");
    LZB = 1'b0;

    cc = carry_cnt;
    tick_n(999);
    read_all(8'h3F, 8'h6F, 8'h6F, 8'h6F, "c0999");
    tick_n(1);
    step();
    LZB = 1'b1;
    read_all(8'h06, 8'h3F, 8'h3F, 8'h3F, "c1000_lzb");
    chk("c1000_no_carry", 32'(carry_cnt - cc), 32'd0);

    HOLD = 1'b1; TICK = 1'b1; step(); HOLD = 1'b0; TICK = 1'b0; step();
    read_all(8'h06, 8'h3F, 8'h3F, 8'h3F, "hold");

    cc = carry_cnt;
    CLR = 1'b1; TICK = 1'b1; step(); CLR = 1'b0; TICK = 1'b0; step();
    LZB = 1'b0;
    read_all(8'h3F, 8'h3F, 8'h3F, 8'h3F, "clr_tick");
    chk("clr_no_carry", 32'(carry_cnt - cc), 32'd0);

    tick_n(5);
    step();
    read_all(8'h3F, 8'h3F, 8'h3F, 8'h6D, "c0005");
    LZB = 1'b1;
    read_all(8'h00, 8'h00, 8'h00, 8'h6D, "c0005_lzb");
    LZB = 1'b0;

    CLR = 1'b1; step(); CLR = 1'b0;
    tick_n(9999);
    chk("c9999_carry_idle", 32'(CARRY), 32'h0);
    read_all(8'h6F, 8'h6F, 8'h6F, 8'h6F, "c9999");
    cc = carry_cnt;
    TICK = 1'b1; step(); TICK = 1'b0;
    chk("roll_carry", 32'(CARRY), 32'h1);
    step();
    chk("roll_carry_end", 32'(CARRY), 32'h0);
    read_all(8'h3F, 8'h3F, 8'h3F, 8'h3F, "roll_0000");
    chk("roll_carry_pulses", 32'(carry_cnt - cc), 32'd1);

    CLR = 1'b1; step(); CLR = 1'b0;
    tick_n(1234);
    step();
    read_all(8'h06, 8'h5B, 8'h4F, 8'h66, "c1234");
    read_seg(4'b0100, 8'h5B, "pre_rst_d2");
    step(); step();
    RST = 1'b1; #1;
    chk("midrst_an", 32'(AN), 32'h0);
    chk("midrst_seg", 32'(Segment), 32'h0);
    chk("midrst_carry", 32'(CARRY), 32'h0);
    step();
    scan_from_reset(13);
    read_all(8'h3F, 8'h3F, 8'h3F, 8'h3F, "post_rst");

    chk("an_onehot", 32'(an_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
